spram256ka_model: RTL and testbench
===================================

# spram256ka_model

Behavioural, synthesizable model of the iCE40UP SB_SPRAM256KA single-port RAM: 16384 words × 16 bits, with nibble write masks and standby, sleep and power-off modes. The SoC pairs two instances to form each 64 KiB, 32-bit CPU RAM bank (high and low halfwords). The model adds an asynchronous reset so that the output state is deterministic in simulation and in the verification bench.

## Interface
Parameters:
- WAKE_CYCLES, default 0: number of clock cycles after SLEEP or POWEROFF is released during which accesses are ignored.

Ports:
- clk  in  1  clock; all sampling on the rising edge.
- resetn  in  1  one clock; reset is asynchronous and active-low.
- ADDRESS  in  14  word address.
- DATAIN  in  16  write data.
- MASKWREN  in  4  per-nibble write enable; bit i covers DATAIN[4i+3:4i].
- WREN  in  1  1 = write, 0 = read.
- CHIPSELECT  in  1  access enable.
- STANDBY  in  1  1 = standby.
- SLEEP  in  1  1 = sleep.
- POWEROFF  in  1  active-low power control; 1 = powered, 0 = off.
- DATAOUT  out  16  registered read data.

## Operation
- **Storage:** 16384×16 array plus one "valid" bit per word. A word whose valid bit is clear reads as 0x0000. All valid bits are clear at time zero.
- **Awake:** POWEROFF=1, SLEEP=0, STANDBY=0, and the wake counter is 0.
- **Mode priority:** POWEROFF=0 > SLEEP=1 > STANDBY=1 > awake.
- **Power-off (POWEROFF=0):**
  - No access is performed.
  - DATAOUT is forced to 0.
  - All valid bits are cleared on every clock in this mode, so contents are lost.
  - The wake counter is loaded with WAKE_CYCLES.
- **Sleep (SLEEP=1):**
  - No access is performed.
  - DATAOUT is forced to 0.
  - Contents are retained.
  - The wake counter is loaded with WAKE_CYCLES.
- **Standby (STANDBY=1):** no access is performed; DATAOUT holds its value; contents are retained. The wake counter is unaffected.
- **Wake counter:** while nonzero and not in power-off or sleep, it decrements once per clock. Accesses are ignored until it reaches 0.
- **Awake, CHIPSELECT=0:** no operation; DATAOUT holds.
- **Awake read (CHIPSELECT=1, WREN=0):** DATAOUT ← stored word at ADDRESS, or 0 if that word is invalid.
- **Awake write (CHIPSELECT=1, WREN=1):**
  - For each i with MASKWREN[i]=1, write nibble i of DATAIN.
  - If the word was invalid, its unmasked nibbles become 0.
  - The valid bit is set.
  - DATAOUT holds its previous value.
  - WREN=1 with MASKWREN=0000 leaves the word unchanged, including its valid state.
- **Reset (resetn=0, asynchronous):** DATAOUT=0 and wake counter=0 immediately. Array contents and valid bits are untouched. A write presented on a clock edge while reset is low is not performed.
- Address wrap is not applicable: all 14-bit addresses are in range.

## Timing
- Read latency is 1 cycle: inputs sampled at edge N appear on DATAOUT after edge N.
- Back-to-back reads stream one word per cycle.
- Read-after-write to the same address on the next cycle returns the new data.
- Mode inputs are sampled at the same clock edge as the access. If SLEEP rises at edge N, the access at N is dropped and DATAOUT becomes 0 after N.
- Reset values of outputs: DATAOUT=0.

## Test plan
- **Write/read:** write 0xBEEF to 0x0123 with MASKWREN=1111, then read 0x0123 → DATAOUT=0xBEEF one cycle later. DATAOUT is unchanged during the write cycle.
- **Masking:**
  - Preload 0x1234 at 0x0001.
  - Write 0xABCD with MASKWREN=0101 → read gives 0x1B3D.
  - Write with MASKWREN=0000 → word unchanged.
- **Power modes:**
  - Write 0x5A5A to 0x3FFF.
  - STANDBY=1 for 3 cycles → DATAOUT holds; a read attempted during standby is ignored.
  - SLEEP=1 → DATAOUT=0; release, then read → 0x5A5A.
  - POWEROFF=0 for 1 cycle → read afterwards gives 0x0000.
- **Wake counter:** set WAKE_CYCLES=3. Pulse SLEEP, then issue reads on each of the next cycles → the first 3 are ignored (DATAOUT stays 0); the 4th returns the stored data.
- **Reset:** assert resetn=0 between clock edges → DATAOUT=0 immediately. Memory is preserved: after release, reading 0x0123 still gives 0xBEEF.
- **Streaming reads:** read addresses 0, 1, 2 on consecutive cycles → data appears in order, one cycle late, with no bubbles.

Source files
------------

// File: rtl/spram256ka_model.sv
// Behavioural model of the iCE40UP SB_SPRAM256KA: 16K x 16 single-port RAM with
// nibble write masks, standby/sleep/power-off modes and a post-wake access blackout.
module spram256ka_model #(
  parameter int unsigned WAKE_CYCLES = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [13:0] ADDRESS,
  input  logic [15:0] DATAIN,
  input  logic [3:0]  MASKWREN,
  input  logic        WREN,
  input  logic        CHIPSELECT,
  input  logic        STANDBY,
  input  logic        SLEEP,
  input  logic        POWEROFF,
  output logic [15:0] DATAOUT
);

  localparam int unsigned WakeW = (WAKE_CYCLES < 1) ? 1 : $clog2(WAKE_CYCLES + 1);
  localparam logic [WakeW-1:0] WakeLoad = WakeW'(WAKE_CYCLES);

  typedef enum logic [1:0] {
    ModeAwake,
    ModeStandby,
    ModeSleep,
    ModeOff
  } modeE;

  logic [15:0]      memQ [16384];
  logic [16383:0]   validQ;
  logic [15:0]      dataOutQ, dataOutD;
  logic [WakeW-1:0] wakeQ, wakeD;

  modeE        mode;
  logic        accessEn;
  logic        doRead;
  logic        doWrite;
  logic [15:0] oldWord;
  logic [15:0] mergedWord;

  // Power-off outranks sleep, which outranks standby.
  always_comb begin
    mode = ModeAwake;
    if (!POWEROFF) begin
      mode = ModeOff;
    end else if (SLEEP) begin
      mode = ModeSleep;
    end else if (STANDBY) begin
      mode = ModeStandby;
    end
  end

  assign accessEn = (mode == ModeAwake) && (wakeQ == '0) && CHIPSELECT;
  assign doRead   = accessEn && !WREN;
  assign doWrite  = accessEn && WREN && (MASKWREN != 4'b0000);

  // Never-written words read as zero, so unmasked nibbles of a first write become zero too.
  assign oldWord = validQ[ADDRESS] ? memQ[ADDRESS] : 16'h0000;

  always_comb begin
    mergedWord = oldWord;
    for (int i = 0; i < 4; i++) begin
      if (MASKWREN[i]) begin
        mergedWord[4*i +: 4] = DATAIN[4*i +: 4];
      end
    end
  end

  always_comb begin
    dataOutD = dataOutQ;
    wakeD    = wakeQ;
    case (mode)
      ModeOff, ModeSleep: begin
        dataOutD = 16'h0000;
        wakeD    = WakeLoad;
      end
      default: begin
        if (wakeQ != '0) begin
          wakeD = wakeQ - WakeW'(1);
        end
        if (doRead) begin
          dataOutD = oldWord;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dataOutQ <= 16'h0000;
      wakeQ    <= '0;
    end else begin
      dataOutQ <= dataOutD;
      wakeQ    <= wakeD;
    end
  end

  // Storage survives reset; only a write with reset released may land.
  always_ff @(posedge clk) begin
    if (resetn && doWrite) begin
      memQ[ADDRESS] <= mergedWord;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      if (mode == ModeOff) begin
        validQ <= '0;
      end else if (doWrite) begin
        validQ[ADDRESS] <= 1'b1;
      end
    end
  end

  assign DATAOUT = dataOutQ;

endmodule

// File: tb/tb_spram256ka_model.sv
// Scoreboard bench for spram256ka_model: directed vectors push expected DATAOUT values,
// a monitor pops and compares them once per cycle.
module tb_spram256ka_model;

  logic        clk;
  logic        resetn;
  logic [13:0] address;
  logic [15:0] dataIn;
  logic [3:0]  maskWren;
  logic        wren;
  logic        chipSelect;
  logic        standby;
  logic        sleep;
  logic        powerOff;
  logic [15:0] dataOut;

  int testsRun = 0;
  int failures = 0;

  string       nameQ [$];
  logic [15:0] expQ [$];

  spram256ka_model #(.WAKE_CYCLES(3)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ADDRESS    (address),
    .DATAIN     (dataIn),
    .MASKWREN   (maskWren),
    .WREN       (wren),
    .CHIPSELECT (chipSelect),
    .STANDBY    (standby),
    .SLEEP      (sleep),
    .POWEROFF   (powerOff),
    .DATAOUT    (dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] expected);
    testsRun++;
    if (dataOut !== expected) begin
      failures++;
      $display("[TB] FAIL %s: DATAOUT=%h expected=%h at %0t", name, dataOut, expected, $time);
    end
  endtask

  // Drive one cycle of inputs; after the edge, record what DATAOUT must then show.
  task automatic applyStimulus(input string name, input logic cs, input logic we,
                               input logic [13:0] addr, input logic [15:0] data,
                               input logic [3:0] mask, input logic stb, input logic slp,
                               input logic pwr, input logic [15:0] expected);
    chipSelect = cs;
    wren       = we;
    address    = addr;
    dataIn     = data;
    maskWren   = mask;
    standby    = stb;
    sleep      = slp;
    powerOff   = pwr;
    @(posedge clk);
    nameQ.push_back(name);
    expQ.push_back(expected);
    @(negedge clk);
  endtask

  task automatic doIdle(input string name, input logic [15:0] expected);
    applyStimulus(name, 1'b0, 1'b0, 14'h0000, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b1, expected);
  endtask

  task automatic doRead(input string name, input logic [13:0] addr, input logic [15:0] expected);
    applyStimulus(name, 1'b1, 1'b0, addr, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b1, expected);
  endtask

  task automatic doWrite(input string name, input logic [13:0] addr, input logic [15:0] data,
                         input logic [3:0] mask, input logic [15:0] expected);
    applyStimulus(name, 1'b1, 1'b1, addr, data, mask, 1'b0, 1'b0, 1'b1, expected);
  endtask

  // Pull reset low mid-cycle; DATAOUT must clear before the next rising edge.
  task automatic asyncReset(input string name);
    chipSelect = 1'b0;
    wren       = 1'b0;
    standby    = 1'b0;
    sleep      = 1'b0;
    powerOff   = 1'b1;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    nameQ.push_back(name);
    expQ.push_back(16'h0000);
    @(negedge clk);
  endtask

  // Monitor: the registered output is presented every cycle, checked at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (expQ.size() > 0) begin
        checkOutput(nameQ.pop_front(), expQ.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn     = 1'b0;
    chipSelect = 1'b0;
    wren       = 1'b0;
    address    = '0;
    dataIn     = '0;
    maskWren   = '0;
    standby    = 1'b0;
    sleep      = 1'b0;
    powerOff   = 1'b1;

    doIdle("reset_state", 16'h0000);
    resetn = 1'b1;

    // Start from a known-empty array: a power-off cycle clears every valid bit.
    applyStimulus("poweroff_init", 1'b0, 1'b0, 14'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) doIdle("wake_idle_init", 16'h0000);

    doWrite("preload_0001",      14'h0001, 16'h1234, 4'b1111, 16'h0000);
    doWrite("write_holds",       14'h0123, 16'hBEEF, 4'b1111, 16'h0000);
    doRead ("read_beef",         14'h0123, 16'hBEEF);
    doWrite("mask0101_holds",    14'h0001, 16'hABCD, 4'b0101, 16'hBEEF);
    doRead ("read_mask0101",     14'h0001, 16'h1B3D);
    doWrite("mask0000_holds",    14'h0001, 16'hFFFF, 4'b0000, 16'h1B3D);
    doRead ("read_mask0000",     14'h0001, 16'h1B3D);
    doWrite("mask0000_invalid",  14'h0002, 16'hFFFF, 4'b0000, 16'h1B3D);
    doRead ("read_still_invalid",14'h0002, 16'h0000);
    doWrite("partial_invalid",   14'h0003, 16'hABCD, 4'b1000, 16'h0000);
    doRead ("read_partial",      14'h0003, 16'hA000);
    doWrite("preload_0000",      14'h0000, 16'h1111, 4'b1111, 16'hA000);

    doRead ("stream_0", 14'h0000, 16'h1111);
    doRead ("stream_1", 14'h0001, 16'h1B3D);
    doRead ("stream_2", 14'h0002, 16'h0000);
    doIdle ("stream_hold", 16'h0000);

    doWrite("write_3fff", 14'h3FFF, 16'h5A5A, 4'b1111, 16'h0000);
    doRead ("read_3fff",  14'h3FFF, 16'h5A5A);
    applyStimulus("standby_read_a", 1'b1, 1'b0, 14'h0001, 16'h0, 4'h0, 1'b1, 1'b0, 1'b1, 16'h5A5A);
    applyStimulus("standby_read_b", 1'b1, 1'b0, 14'h0000, 16'h0, 4'h0, 1'b1, 1'b0, 1'b1, 16'h5A5A);
    applyStimulus("standby_write",  1'b1, 1'b1, 14'h3FFF, 16'h0000, 4'hF, 1'b1, 1'b0, 1'b1, 16'h5A5A);
    doRead ("after_standby_0001", 14'h0001, 16'h1B3D);
    doRead ("after_standby_3fff", 14'h3FFF, 16'h5A5A);

    applyStimulus("sleep_read", 1'b1, 1'b0, 14'h3FFF, 16'h0, 4'h0, 1'b0, 1'b1, 1'b1, 16'h0000);
    for (int i = 0; i < 3; i++) doRead("wake_ignored", 14'h3FFF, 16'h0000);
    doRead("wake_done", 14'h3FFF, 16'h5A5A);

    applyStimulus("poweroff_read", 1'b1, 1'b0, 14'h3FFF, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) doRead("poweroff_wake", 14'h3FFF, 16'h0000);
    doRead("poweroff_lost_3fff", 14'h3FFF, 16'h0000);
    doRead("poweroff_lost_0123", 14'h0123, 16'h0000);

    doWrite("rewrite_beef",    14'h0123, 16'hBEEF, 4'b1111, 16'h0000);
    doRead ("read_beef_again", 14'h0123, 16'hBEEF);

    asyncReset("reset_async");
    applyStimulus("write_in_reset", 1'b1, 1'b1, 14'h0123, 16'h1111, 4'hF, 1'b0, 1'b0, 1'b1, 16'h0000);
    resetn = 1'b1;
    doRead("reset_kept_mem", 14'h0123, 16'hBEEF);

    applyStimulus("sleep_before_reset", 1'b0, 1'b0, 14'h0, 16'h0, 4'h0, 1'b0, 1'b1, 1'b1, 16'h0000);
    asyncReset("reset_clears_out");
    resetn = 1'b1;
    doRead("reset_wake_cleared", 14'h0123, 16'hBEEF);

    @(posedge clk);
    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
